// File: rtl/miner_job_ctrl.sv
// miner_job_ctrl
// Host-side controller that takes one job at a time from a valid/ready source,
// restarts the nonce-search miner with that job, and returns one result per job
// (found nonce or timeout) over a second valid/ready handshake.
//
// Job lifecycle: IDLE -> LOAD -> RUN -> DONE -> IDLE.
//  - LOAD holds miner_run low for one full cycle with the new data/target already
//    stable, so the miner always restarts cleanly on the new job.
//  - RUN counts the cycles the miner has spent searching. A finish reported by
//    the miner beats a timeout that expires on the same cycle.
//  - DONE holds the result until the consumer takes it.
// Everything the miner or the result consumer sees is registered; only
// job_ready and busy are decoded directly from the state.

module miner_job_ctrl #(
    parameter int          BYTE    = 8,
    parameter logic [31:0] TIMEOUT = 32'd0,
    parameter int          CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [BYTE*12-1:0]   job_data,
    input  logic [7:0]           job_target,

    output logic                 miner_run,
    output logic [BYTE*12-1:0]   miner_data,
    output logic [7:0]           miner_target,
    input  logic                 miner_finished,
    input  logic [31:0]          miner_nonce,

    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_nonce,
    output logic                 res_timeout,
    output logic [CNT_W-1:0]     res_cycles,

    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // A zero TIMEOUT disables the abort path entirely.
    localparam logic             TO_EN     = (TIMEOUT != 32'd0);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] TO_CYCLES = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic                 timeoutHit;

    logic                 miner_run_q;
    logic [BYTE*12-1:0]   miner_data_q;
    logic [7:0]           miner_target_q;
    logic                 res_valid_q;
    logic [31:0]          res_nonce_q;
    logic                 res_timeout_q;
    logic [CNT_W-1:0]     res_cycles_q;

    // Next value of the RUN cycle counter: increments but sticks at all-ones
    // so a very long job never reports a wrapped (too small) cycle count.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // The counter holds the number of completed RUN cycles before this edge,
    // so the last allowed cycle is the one where it equals TIMEOUT-1.
    assign timeoutHit = TO_EN && (cnt_q == TO_LAST);

    // Job FSM together with every registered output it drives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            miner_run_q    <= 1'b0;
            miner_data_q   <= '0;
            miner_target_q <= '0;
            res_valid_q    <= 1'b0;
            res_nonce_q    <= '0;
            res_timeout_q  <= 1'b0;
            res_cycles_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    miner_run_q <= 1'b0;
                    if (job_valid) begin
                        miner_data_q   <= job_data;
                        miner_target_q <= job_target;
                        state_q        <= LOAD;
                    end
                end

                LOAD: begin
                    miner_run_q <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= RUN;
                end

                RUN: begin
                    if (miner_finished) begin
                        res_nonce_q   <= miner_nonce;
                        res_timeout_q <= 1'b0;
                        res_cycles_q  <= cnt_d;
                        res_valid_q   <= 1'b1;
                        miner_run_q   <= 1'b0;
                        state_q       <= DONE;
                    end else if (timeoutHit) begin
                        res_nonce_q   <= '0;
                        res_timeout_q <= 1'b1;
                        res_cycles_q  <= TO_CYCLES;
                        res_valid_q   <= 1'b1;
                        miner_run_q   <= 1'b0;
                        state_q       <= DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    miner_run_q <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign job_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign miner_run    = miner_run_q;
    assign miner_data   = miner_data_q;
    assign miner_target = miner_target_q;
    assign res_valid    = res_valid_q;
    assign res_nonce    = res_nonce_q;
    assign res_timeout  = res_timeout_q;
    assign res_cycles   = res_cycles_q;

endmodule

// File: tb/tb_miner_job_ctrl.sv
// Testbench for miner_job_ctrl.
// Two controllers share clock and reset: index 0 has no timeout, index 1 aborts
// after 50 RUN cycles. A small behavioural miner per controller raises finished
// after a programmed number of cycles in which it saw miner_run high.

module tb_miner_job_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic          jobValid      [2];
    logic          jobReady      [2];
    logic [95:0]   jobData       [2];
    logic [7:0]    jobTarget     [2];
    logic          minerRun      [2];
    logic [95:0]   minerData     [2];
    logic [7:0]    minerTarget   [2];
    logic          minerFinished [2];
    logic [31:0]   minerNonce    [2];
    logic          resValid      [2];
    logic          resReady      [2];
    logic [31:0]   resNonce      [2];
    logic          resTimeout    [2];
    logic [31:0]   resCycles     [2];
    logic          busy          [2];

    int            finDelay [2];
    logic [31:0]   finNonce [2];
    logic          staleFin [2];
    int            runSeen  [2];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          inst;
        logic [95:0] data;
        logic [7:0]  target;
        int          delay;
        logic [31:0] nonce;
        int          hold;
        logic        expTo;
        logic [31:0] expNonce;
        logic [31:0] expCycles;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gDut
        miner_job_ctrl #(
            .BYTE    (8),
            .TIMEOUT ((g == 0) ? 32'd0 : 32'd50),
            .CNT_W   (32)
        ) dut (
            .clk            (clk),
            .reset          (reset),
            .job_valid      (jobValid[g]),
            .job_ready      (jobReady[g]),
            .job_data       (jobData[g]),
            .job_target     (jobTarget[g]),
            .miner_run      (minerRun[g]),
            .miner_data     (minerData[g]),
            .miner_target   (minerTarget[g]),
            .miner_finished (minerFinished[g]),
            .miner_nonce    (minerNonce[g]),
            .res_valid      (resValid[g]),
            .res_ready      (resReady[g]),
            .res_nonce      (resNonce[g]),
            .res_timeout    (resTimeout[g]),
            .res_cycles     (resCycles[g]),
            .busy           (busy[g])
        );
    end

    // Behavioural miner: the value of miner_run at a falling edge is what the
    // controller presents at the next rising edge, so counting it here counts
    // RUN cycles. When not running it drives the stale-finished level and junk.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (minerRun[i] === 1'b1) begin
                runSeen[i]       = runSeen[i] + 1;
                minerFinished[i] = (finDelay[i] != 0) && (runSeen[i] == finDelay[i]);
                minerNonce[i]    = finNonce[i];
            end else begin
                runSeen[i]       = 0;
                minerFinished[i] = staleFin[i];
                minerNonce[i]    = 32'hDEAD_BEEF;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected result from the job rules: a timeout limit L aborts any job whose
    // finish would come later than cycle L (or never); otherwise the nonce is
    // returned with the cycle count at which the miner finished.
    task automatic refResult(input int i, input int delay, input logic [31:0] n,
                             output logic to, output logic [31:0] en, output logic [31:0] ec);
        int limit;
        limit = (i == 0) ? 0 : 50;
        if (limit != 0 && (delay == 0 || delay > limit)) begin
            to = 1'b1; en = 32'd0; ec = limit;
        end else begin
            to = 1'b0; en = n; ec = delay;
        end
    endtask

    task automatic checkReset(input string tag);
        for (int i = 0; i < 2; i++) begin
            checkOutput({tag, ".run"},    minerRun[i],    1'b0);
            checkOutput({tag, ".data"},   minerData[i],   96'd0);
            checkOutput({tag, ".target"}, minerTarget[i], 8'd0);
            checkOutput({tag, ".valid"},  resValid[i],    1'b0);
            checkOutput({tag, ".nonce"},  resNonce[i],    32'd0);
            checkOutput({tag, ".tmo"},    resTimeout[i],  1'b0);
            checkOutput({tag, ".cycles"}, resCycles[i],   32'd0);
            checkOutput({tag, ".busy"},   busy[i],        1'b0);
            checkOutput({tag, ".ready"},  jobReady[i],    1'b1);
        end
    endtask

    // Offer a job, then check the one-cycle LOAD gap and the miner_run rise.
    task automatic applyStimulus(input int i, input logic [95:0] d, input logic [7:0] t,
                                 input int delay, input logic [31:0] n, output bit ok);
        int w;
        ok = 1'b0;
        w  = 0;
        @(negedge clk);
        while (!jobReady[i] && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!jobReady[i]) begin
            checkOutput("readyWait", jobReady[i], 1'b1);
            return;
        end
        finDelay[i]  = delay;
        finNonce[i]  = n;
        jobData[i]   = d;
        jobTarget[i] = t;
        jobValid[i]  = 1'b1;
        @(posedge clk);
        #1;
        jobValid[i] = 1'b0;
        checkOutput("load.data",   minerData[i],   d);
        checkOutput("load.target", minerTarget[i], t);
        checkOutput("load.run",    minerRun[i],    1'b0);
        checkOutput("load.busy",   busy[i],        1'b1);
        checkOutput("load.ready",  jobReady[i],    1'b0);
        @(posedge clk);
        #1;
        checkOutput("run.rise",  minerRun[i], 1'b1);
        checkOutput("run.valid", resValid[i], 1'b0);
        ok = 1'b1;
    endtask

    // Wait for the result, check it, then optionally hold it under backpressure
    // while a competing job is offered.
    task automatic waitResult(input int i, input logic expTo, input logic [31:0] expN,
                              input logic [31:0] expC, input int hold, input string tag);
        int w;
        int runCnt;
        bit stable;
        w      = 0;
        runCnt = 0;
        stable = 1'b1;
        @(negedge clk);
        while (!resValid[i] && w < 400) begin
            if (minerRun[i]) runCnt++;
            @(negedge clk);
            w++;
        end
        checkOutput({tag, ".valid"}, resValid[i], 1'b1);
        if (!resValid[i]) return;
        checkOutput({tag, ".runDrop"},   minerRun[i],   1'b0);
        checkOutput({tag, ".runCycles"}, runCnt,        expC);
        checkOutput({tag, ".tmo"},       resTimeout[i], expTo);
        checkOutput({tag, ".nonce"},     resNonce[i],   expN);
        checkOutput({tag, ".cycles"},    resCycles[i],  expC);
        checkOutput({tag, ".ready"},     jobReady[i],   1'b0);
        if (hold > 0) begin
            jobValid[i] = 1'b1;
            jobData[i]  = 96'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
            repeat (hold) begin
                @(negedge clk);
                stable &= resValid[i] && (resNonce[i] == expN) && (resTimeout[i] == expTo)
                          && (resCycles[i] == expC) && !jobReady[i] && busy[i];
            end
            checkOutput({tag, ".hold"}, stable, 1'b1);
            jobValid[i] = 1'b0;
        end
    endtask

    task automatic consume(input int i, input string tag);
        resReady[i] = 1'b1;
        @(posedge clk);
        #1;
        resReady[i] = 1'b0;
        checkOutput({tag, ".drop"},  resValid[i], 1'b0);
        checkOutput({tag, ".idle"},  busy[i],     1'b0);
        checkOutput({tag, ".ready"}, jobReady[i], 1'b1);
    endtask

    initial begin
        bit          ok;
        bit          noValid;
        logic        eTo;
        logic [31:0] eN;
        logic [31:0] eC;

        for (int i = 0; i < 2; i++) begin
            jobValid[i]  = 1'b0;
            jobData[i]   = '0;
            jobTarget[i] = '0;
            resReady[i]  = 1'b0;
            finDelay[i]  = 0;
            finNonce[i]  = '0;
            staleFin[i]  = 1'b0;
            runSeen[i]   = 0;
        end

        vecs[0] = '{0, 96'h3c87edfd24331f6b6c9eca40, 8'd150, 100, 32'h0000_1234, 0, 1'b0, 32'h0000_1234, 32'd100};
        vecs[1] = '{1, 96'h0123456789abcdef01234567, 8'h20,    0, 32'h5555_5555, 2, 1'b1, 32'h0000_0000, 32'd50};
        vecs[2] = '{1, 96'hfeedfacecafebeef00112233, 8'h10,   50, 32'h0000_abcd, 0, 1'b0, 32'h0000_abcd, 32'd50};
        vecs[3] = '{1, 96'h111111112222222233333333, 8'h01,    1, 32'hffff_ffff, 0, 1'b0, 32'hffff_ffff, 32'd1};
        vecs[4] = '{1, 96'h444444445555555566666666, 8'h7f,   49, 32'h1357_9bdf, 1, 1'b0, 32'h1357_9bdf, 32'd49};
        vecs[5] = '{1, 96'h777777778888888899999999, 8'h80,   51, 32'h2468_ace0, 0, 1'b1, 32'h0000_0000, 32'd50};
        vecs[6] = '{0, 96'haaaaaaaabbbbbbbbcccccccc, 8'hff,    1, 32'h0bad_f00d, 0, 1'b0, 32'h0bad_f00d, 32'd1};
        vecs[7] = '{0, 96'hdddddddd00000000eeeeeeee, 8'h00,    7, 32'h8000_0001, 3, 1'b0, 32'h8000_0001, 32'd7};

        #2 reset = 1'b1;
        #1 checkReset("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] directed vectors");
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].inst, vecs[v].data, vecs[v].target, vecs[v].delay, vecs[v].nonce, ok);
            if (ok) begin
                waitResult(vecs[v].inst, vecs[v].expTo, vecs[v].expNonce, vecs[v].expCycles, vecs[v].hold, $sformatf("vec%0d", v));
                consume(vecs[v].inst, $sformatf("vec%0d", v));
            end
        end

        $display("[TB] backpressure and back-to-back job");
        applyStimulus(1, 96'hA5A5A5A5A5A5A5A5A5A5A5A5, 8'h33, 10, 32'h0000_0A0A, ok);
        if (ok) begin
            waitResult(1, 1'b0, 32'h0000_0A0A, 32'd10, 20, "bp");
            resReady[1]  = 1'b1;
            jobValid[1]  = 1'b1;
            jobData[1]   = 96'h5A5A5A5A5A5A5A5A5A5A5A5A;
            jobTarget[1] = 8'h44;
            finDelay[1]  = 5;
            finNonce[1]  = 32'h0000_0B0B;
            @(posedge clk);
            #1;
            resReady[1] = 1'b0;
            checkOutput("bp.release.valid", resValid[1],  1'b0);
            checkOutput("bp.release.busy",  busy[1],      1'b0);
            checkOutput("bp.release.ready", jobReady[1],  1'b1);
            checkOutput("bp.release.data",  minerData[1], 96'hA5A5A5A5A5A5A5A5A5A5A5A5);
            @(posedge clk);
            #1;
            jobValid[1] = 1'b0;
            checkOutput("bp.next.busy",   busy[1],        1'b1);
            checkOutput("bp.next.data",   minerData[1],   96'h5A5A5A5A5A5A5A5A5A5A5A5A);
            checkOutput("bp.next.target", minerTarget[1], 8'h44);
            checkOutput("bp.next.run",    minerRun[1],    1'b0);
            @(posedge clk);
            #1;
            checkOutput("bp.next.rise", minerRun[1], 1'b1);
            waitResult(1, 1'b0, 32'h0000_0B0B, 32'd5, 0, "bp2");
            consume(1, "bp2");
        end

        $display("[TB] stale finished outside RUN");
        staleFin[0] = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("stale.idle.valid", resValid[0], 1'b0);
        checkOutput("stale.idle.busy",  busy[0],     1'b0);
        applyStimulus(0, 96'h0F0F0F0F0F0F0F0F0F0F0F0F, 8'h55, 30, 32'h0000_3030, ok);
        if (ok) begin
            waitResult(0, 1'b0, 32'h0000_3030, 32'd30, 0, "stale");
            consume(0, "stale");
        end
        staleFin[0] = 1'b0;

        $display("[TB] async reset during RUN");
        applyStimulus(1, 96'hC0FFEE00C0FFEE00C0FFEE00, 8'h66, 0, 32'h1111_2222, ok);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 checkReset("asyncReset");
        #1 reset = 1'b0;
        noValid = 1'b1;
        repeat (60) begin
            @(negedge clk);
            noValid &= !resValid[0] && !resValid[1] && !busy[1];
        end
        checkOutput("asyncReset.quiet", noValid, 1'b1);
        applyStimulus(1, 96'h123123123123123123123123, 8'h77, 20, 32'h0000_2020, ok);
        if (ok) begin
            waitResult(1, 1'b0, 32'h0000_2020, 32'd20, 0, "postReset");
            consume(1, "postReset");
        end

        $display("[TB] randomized jobs");
        for (int r = 0; r < 16; r++) begin
            int          inst;
            int          delay;
            int          hold;
            logic [31:0] n;
            logic [95:0] d;
            logic [7:0]  t;
            inst  = r % 2;
            delay = $urandom_range(80, 1);
            hold  = $urandom_range(5, 0);
            n     = $urandom;
            d     = {$urandom, $urandom, $urandom};
            t     = 8'($urandom);
            refResult(inst, delay, n, eTo, eN, eC);
            applyStimulus(inst, d, t, delay, n, ok);
            if (ok) begin
                waitResult(inst, eTo, eN, eC, hold, $sformatf("rand%0d", r));
                consume(inst, $sformatf("rand%0d", r));
            end
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
